// File: rtl/requant_serializer.sv
// requant_serializer: captures a systolic-array result vector, requantizes every
// element to OUT_WIDTH bits, then streams the elements out one per beat with a
// frame-based o_last marker.
`timescale 1ns/1ps

module requant_serializer #(
    parameter int SA_ROWS   = 3,
    parameter int SA_COLS   = 1,
    parameter int C_WIDTH   = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_pre_valid,
    output logic                         o_pre_ready,
    input  logic signed [C_WIDTH-1:0]    i_c [SA_COLS-1:0][SA_ROWS-1:0],
    input  logic [$clog2(C_WIDTH)-1:0]   i_shift,
    input  logic                         i_relu_en,
    input  logic [15:0]                  i_frame_len,
    output logic                         o_post_valid,
    input  logic                         i_post_ready,
    output logic [OUT_WIDTH-1:0]         o_data,
    output logic                         o_last
);

    localparam int N_ELEM  = SA_COLS * SA_ROWS;
    localparam int IDX_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int SHIFT_W = $clog2(C_WIDTH);

    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(N_ELEM - 1);
    localparam logic signed [C_WIDTH:0] SAT_MAX = (C_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [C_WIDTH:0] SAT_MIN = (C_WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [15:0]          frame_cnt_q;
    logic [OUT_WIDTH-1:0] results_q [N_ELEM];
    logic [OUT_WIDTH-1:0] rq_d      [N_ELEM];

    logic out_fire;
    logic idx_is_last;
    logic capture;

    // Round-half-up arithmetic shift in C_WIDTH+1 bits (the rounding add cannot
    // wrap), optional ReLU, then saturation to the signed OUT_WIDTH range.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic signed [C_WIDTH-1:0] c,
        input logic [SHIFT_W-1:0]        shift,
        input logic                      relu
    );
        logic signed [C_WIDTH:0] ext;
        logic signed [C_WIDTH:0] rnd;
        logic signed [C_WIDTH:0] v;
        ext = {c[C_WIDTH-1], c};
        rnd = (C_WIDTH+1)'(1) << shift;
        rnd = rnd >> 1;
        if (shift == '0) begin
            v = ext;
        end else begin
            v = (ext + rnd) >>> shift;
        end
        if (relu && v[C_WIDTH]) begin
            v = '0;
        end
        if (v > SAT_MAX) begin
            v = SAT_MAX;
        end else if (v < SAT_MIN) begin
            v = SAT_MIN;
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    // Handshake decode: a new vector may enter when idle, or on the very beat that
    // drains the last element of the current one, so vectors stream without bubbles.
    assign o_post_valid = (state_q == ST_SEND);
    assign out_fire     = o_post_valid && i_post_ready;
    assign idx_is_last  = (idx_q == IDX_LAST);
    assign o_pre_ready  = !o_post_valid || (out_fire && idx_is_last);
    assign capture      = i_pre_valid && o_pre_ready;
    assign o_data       = o_post_valid ? results_q[idx_q] : '0;
    assign o_last       = o_post_valid && (frame_cnt_q == (i_frame_len - 16'd1));

    // Requantize the whole incoming vector in element order col*SA_ROWS + row.
    always_comb begin
        // NOTE: every rq_d entry is written on every evaluation, so no latch is inferred.
        for (int col = 0; col < SA_COLS; col++) begin
            for (int row = 0; row < SA_ROWS; row++) begin
                rq_d[col*SA_ROWS + row] = requant(i_c[col][row], i_shift, i_relu_en);
            end
        end
    end

    // Serializer state, element index, stored results and the frame counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            // NOTE: the result store is cleared too, so nothing from an aborted
            // vector survives reset; most datapath memories would be left unreset.
            for (int e = 0; e < N_ELEM; e++) begin
                results_q[e] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (capture) begin
                results_q <= rq_d;
                state_q   <= ST_SEND;
                idx_q     <= '0;
            end else if (out_fire) begin
                if (idx_is_last) begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (out_fire) begin
                frame_cnt_q <= o_last ? 16'd0 : frame_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_requant_serializer.sv
// Directed self-checking bench for requant_serializer (SA_ROWS=3, SA_COLS=1).
`timescale 1ns/1ps

module tb_requant_serializer;

    localparam int SA_ROWS   = 3;
    localparam int SA_COLS   = 1;
    localparam int C_WIDTH   = 16;
    localparam int OUT_WIDTH = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        pre_valid = 1'b0;
    logic                        pre_ready;
    logic signed [C_WIDTH-1:0]   c_arr [SA_COLS-1:0][SA_ROWS-1:0];
    logic [$clog2(C_WIDTH)-1:0]  shift = '0;
    logic                        relu_en = 1'b0;
    logic [15:0]                 frame_len = 16'd3;
    logic                        post_valid;
    logic                        post_ready = 1'b1;
    logic [OUT_WIDTH-1:0]        data;
    logic                        last;

    int n_checks = 0;
    int n_pass   = 0;

    requant_serializer #(
        .SA_ROWS  (SA_ROWS),
        .SA_COLS  (SA_COLS),
        .C_WIDTH  (C_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pre_valid (pre_valid),
        .o_pre_ready (pre_ready),
        .i_c         (c_arr),
        .i_shift     (shift),
        .i_relu_en   (relu_en),
        .i_frame_len (frame_len),
        .o_post_valid(post_valid),
        .i_post_ready(post_ready),
        .o_data      (data),
        .o_last      (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input logic signed [15:0] c0, input logic signed [15:0] c1,
                            input logic signed [15:0] c2, input logic [3:0] sh, input logic relu);
        c_arr[0][0] = c0;
        c_arr[0][1] = c1;
        c_arr[0][2] = c2;
        shift       = sh;
        relu_en     = relu;
    endtask

    // Junk on the vector inputs: the DUT must ignore these outside a capture.
    task automatic scramble();
        load_vec(16'sh1234, -16'sd77, 16'sh0055, 4'd0, 1'b1);
    endtask

    // Capture one vector, then stream nvec copies back to back with ready held high.
    task automatic stream(input string tag,
                          input logic signed [15:0] c0, input logic signed [15:0] c1,
                          input logic signed [15:0] c2, input logic [3:0] sh, input logic relu,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input int nvec, input logic [11:0] last_mask);
        logic [7:0] exp_d [3];
        exp_d[0] = e0;
        exp_d[1] = e1;
        exp_d[2] = e2;
        load_vec(c0, c1, c2, sh, relu);
        pre_valid  = 1'b1;
        post_ready = 1'b1;
        #1;
        check({tag, ".rdy_idle"}, pre_ready, 1);
        step();
        for (int b = 0; b < 3 * nvec; b++) begin
            pre_valid = (b % 3 == 2) && (b / 3 < nvec - 1);
            if (pre_valid) load_vec(c0, c1, c2, sh, relu);
            else           scramble();
            #1;
            check($sformatf("%s.valid%0d", tag, b), post_valid, 1);
            check($sformatf("%s.data%0d", tag, b), data, exp_d[b % 3]);
            check($sformatf("%s.last%0d", tag, b), last, last_mask[b]);
            check($sformatf("%s.prdy%0d", tag, b), pre_ready, (b % 3 == 2));
            step();
        end
        pre_valid = 1'b0;
        #1;
        check({tag, ".idle"}, post_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        scramble();
        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst.valid", post_valid, 0);
        check("rst.data", data, 0);
        check("rst.last", last, 0);
        check("rst.prdy", pre_ready, 1);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_rel.prdy", pre_ready, 1);

        // Single vectors, frame_len=3 so o_last lands on element 2 each time
        stream("v1", 16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b0, 8'h03, 8'hFE, 8'h7F, 1, 12'h004);
        stream("v2", 16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b1, 8'h03, 8'h00, 8'h7F, 1, 12'h004);
        stream("v3", -16'sd200, 16'sd5, 16'sd127, 4'd0, 1'b0, 8'h80, 8'h05, 8'h7F, 1, 12'h004);
        stream("v4", 16'sh7FFF, 16'sh8000, -16'sd1, 4'd1, 1'b0, 8'h7F, 8'h80, 8'h00, 1, 12'h004);
        stream("v5", 16'sd16384, -16'sd16385, 16'sh7FFF, 4'd15, 1'b0, 8'h01, 8'hFF, 8'h01, 1, 12'h004);

        // Backpressure on element 1, then a back-to-back capture on element 2
        load_vec(16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b0);
        pre_valid  = 1'b1;
        post_ready = 1'b1;
        step();
        pre_valid = 1'b0;
        scramble();
        #1;
        check("bp.d0", data, 8'h03);
        check("bp.prdy0", pre_ready, 0);
        step();
        post_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp.hold_data%0d", k), data, 8'hFE);
            check($sformatf("bp.hold_valid%0d", k), post_valid, 1);
            check($sformatf("bp.hold_prdy%0d", k), pre_ready, 0);
            check($sformatf("bp.hold_last%0d", k), last, 0);
            step();
        end
        post_ready = 1'b1;
        #1;
        check("bp.d1", data, 8'hFE);
        step();
        load_vec(-16'sd200, 16'sd5, 16'sd127, 4'd0, 1'b0);
        pre_valid = 1'b1;
        #1;
        check("bp.d2", data, 8'h7F);
        check("bp.last2", last, 1);
        check("bp.prdy2", pre_ready, 1);
        step();
        pre_valid = 1'b0;
        scramble();
        #1;
        check("bp.nx_valid", post_valid, 1);
        check("bp.nx_d0", data, 8'h80);
        check("bp.nx_last0", last, 0);
        step();
        check("bp.nx_d1", data, 8'h05);
        step();
        check("bp.nx_d2", data, 8'h7F);
        check("bp.nx_last2", last, 1);
        step();
        check("bp.nx_idle", post_valid, 0);

        // Frame of 4 across three vectors: o_last on beats 3 and 7 only
        frame_len = 16'd4;
        stream("frm4", 16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b0, 8'h03, 8'hFE, 8'h7F, 3, 12'h088);

        // Asynchronous reset mid-vector, right after beat 1 is presented
        load_vec(16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b0);
        pre_valid = 1'b1;
        step();
        pre_valid = 1'b0;
        scramble();
        step();
        #1;
        check("arst.pre_d1", data, 8'hFE);
        #2 rst = 1'b1;
        #1;
        check("arst.valid", post_valid, 0);
        check("arst.data", data, 0);
        check("arst.last", last, 0);
        check("arst.prdy", pre_ready, 1);
        step();
        rst = 1'b0;
        step();
        check("arst.no_reemit", post_valid, 0);
        check("arst.prdy_rel", pre_ready, 1);
        // Counter restarted at 0: with frame_len=4 the 4th beat is the last one
        stream("post_rst", -16'sd200, 16'sd5, 16'sd127, 4'd0, 1'b0, 8'h80, 8'h05, 8'h7F, 2, 12'h008);

        // frame_len=0 means 65536: no o_last within 9 beats
        rst = 1'b1;
        step();
        rst = 1'b0;
        frame_len = 16'd0;
        step();
        stream("frm0", 16'sd10, -16'sd10, 16'sd1000, 4'd2, 1'b0, 8'h03, 8'hFE, 8'h7F, 3, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/requant_serializer.md
REQUANT_SERIALIZER -- requirements
Module: requant_serializer

Interface
REQ-001 SHALL have parameter SA_ROWS, default 3, rows per result column.
REQ-002 SHALL have parameter SA_COLS, default 1, result columns per vector.
REQ-003 SHALL have parameter C_WIDTH, default 16, signed accumulator width.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, signed output width.
REQ-005 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_pre_valid  input  1  upstream result vector valid.
REQ-008 SHALL have port o_pre_ready  output  1  block can accept a vector this cycle.
REQ-009 SHALL have port i_c  input  [C_WIDTH-1:0] x [SA_COLS-1:0][SA_ROWS-1:0]  signed result vector.
REQ-010 SHALL have port i_shift  input  $clog2(C_WIDTH)  right-shift amount.
REQ-011 SHALL have port i_relu_en  input  1  clamp negatives to zero.
REQ-012 SHALL have port i_frame_len  input  16  elements per frame; 0 means 65536.
REQ-013 SHALL have port o_post_valid  output  1  o_data valid.
REQ-014 SHALL have port i_post_ready  input  1  downstream accepts o_data.
REQ-015 SHALL have port o_data  output  OUT_WIDTH  requantized element, two's complement.
REQ-016 SHALL have port o_last  output  1  qualifies final element of a frame.

Function
REQ-017 SHALL accept a vector on a cycle with i_pre_valid && o_pre_ready (capture).
REQ-018 SHALL drive o_pre_ready = !busy || (o_post_valid && i_post_ready && idx == SA_COLS*SA_ROWS-1), giving back-to-back vectors without bubbles.
REQ-019 SHALL, at capture, requantize all elements and store OUT_WIDTH results; i_shift and i_relu_en are sampled at capture only.
REQ-020 SHALL compute per element: shift==0 -> v = c; else v = (c + 2^(shift-1)) >>> shift, using a C_WIDTH+1-bit signed intermediate (no wrap).
REQ-021 SHALL saturate v to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; with relu enabled, to [0, 2^(OUT_WIDTH-1)-1].
REQ-022 SHALL emit elements in order e = col*SA_ROWS + row, e = 0..SA_COLS*SA_ROWS-1, one element per accepted output beat.
REQ-023 SHALL assert o_post_valid in the cycle after capture (latency 1) and keep it asserted until the last element is accepted.
REQ-024 SHALL hold o_data and o_last stable while o_post_valid && !i_post_ready; idx advances only on a handshake.
REQ-025 SHALL, when the last element is accepted without a capture in the same cycle, deassert o_post_valid next cycle (busy = 0); with a simultaneous capture, present element 0 of the new vector next cycle.
REQ-026 SHALL keep a 16-bit frame counter of accepted output elements; o_last = o_post_valid && (count == i_frame_len-1, mod 2^16); the counter wraps to 0 after the o_last beat.
REQ-027 SHALL treat frames as independent of vector boundaries (a frame may end mid-vector).
REQ-028 SHALL require i_frame_len to change only when the frame counter is 0 and busy is 0; behaviour otherwise is undefined.
REQ-029 SHALL ignore i_c, i_shift and i_relu_en when no capture occurs.

Reset
REQ-030 SHALL on i_rst assertion, immediately and regardless of clock: o_post_valid=0, o_last=0, o_data=0, busy=0, idx=0, frame counter=0, stored results cleared.
REQ-031 SHALL drive o_pre_ready=1 during and after reset.
REQ-032 SHALL discard any partially serialized vector when reset is asserted mid-operation; no element is re-emitted after release.

Verification
REQ-033 SHALL cover, with SA_ROWS=3 and SA_COLS=1: i_c={10,-10,1000}, shift=2, relu=0, ready=1 -> o_data 0x03, 0xFE, 0x7F on consecutive cycles starting 1 cycle after capture.
REQ-034 SHALL cover the same vector with relu=1 -> 0x03, 0x00, 0x7F; with shift=0 and i_c={-200,5,127} -> 0x80, 0x05, 0x7F.
REQ-035 SHALL cover rounding overflow: i_c={0x7FFF,...}, shift=1 -> 0x7F (no wrap to negative).
REQ-036 SHALL cover backpressure: i_post_ready low 4 cycles on element 1 -> o_data held, o_pre_ready=0; then the remaining beats are output and the next vector is accepted with no gap.
REQ-037 SHALL cover frames: frame_len=4 over 3 vectors -> o_last on beats 3 and 7 only; frame_len=0 -> no o_last within 9 beats.
REQ-038 SHALL cover asynchronous reset asserted after beat 1 -> o_post_valid=0 in the same cycle; a new vector after release restarts at element 0 with the counter at 0.
